// File: rtl/subtrator_pkg.sv
// Shared definitions for the ripple-borrow subtractor: default width and the
// per-bit borrow equation.
package subtrator_pkg;

  localparam int DEFAULT_WIDTH = 1;

  function automatic logic borrow_out(input logic a, input logic b, input logic bin);
    return (~a & b) | (~a & bin) | (b & bin);
  endfunction

endpackage

// File: rtl/subtrator_completo_if.sv
// Operand/result bundle for the registered subtractor.
interface subtrator_completo_if
  import subtrator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             out_valid;

  modport master (output in_valid, a, b, cin, input s, cout, out_valid);
  modport slave  (input in_valid, a, b, cin, output s, cout, out_valid);
endinterface

// File: rtl/subtrator_bit.sv
// Combinational 1-bit full-subtractor cell: d = a - b - bin, bout = borrow.
module subtrator_bit
  import subtrator_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = borrow_out(a, b, bin);
endmodule

// File: rtl/subtrator_completo.sv
// Registered ripple-borrow subtractor: {cout, s} = a - b - cin, 1-cycle latency.
module subtrator_completo
  import subtrator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  subtrator_completo_if.slave bus
);
  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] diff;

  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             vld_q, vld_d;

  assign borrow[0] = bus.cin;

  // Borrow ripples from bit 0 upward; borrow[WIDTH] is the final borrow-out.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    subtrator_bit u_bit (
      .a    (bus.a[i]),
      .b    (bus.b[i]),
      .bin  (borrow[i]),
      .d    (diff[i]),
      .bout (borrow[i+1])
    );
  end

  always_comb begin
    s_d    = s_q;
    cout_d = cout_q;
    vld_d  = bus.in_valid;
    if (bus.in_valid) begin
      s_d    = diff;
      cout_d = borrow[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      vld_q  <= vld_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_subtrator_completo.sv
// Directed and random checks of the registered subtractor at WIDTH 1 and 8.
module tb_subtrator_completo;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  subtrator_completo_if #(.WIDTH(1)) if1 ();
  subtrator_completo_if #(.WIDTH(8)) if8 ();

  subtrator_completo #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  subtrator_completo #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if1.in_valid = 1'b1; if1.a = 1'b1; if1.b = 1'b0; if1.cin = 1'b0;
    if8.in_valid = 1'b1; if8.a = 8'h01; if8.b = 8'h00; if8.cin = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if ({if1.s, if1.cout, if1.out_valid} !== 3'b000) begin
        n_bad++;
        $display("FAIL reset_w1 cyc%0d: got s=%b cout=%b vld=%b, want 0 0 0",
                 c, if1.s, if1.cout, if1.out_valid);
      end
      n_cmp++;
      if ({if8.s, if8.cout, if8.out_valid} !== 10'b0) begin
        n_bad++;
        $display("FAIL reset_w8 cyc%0d: got s=%h cout=%b vld=%b, want 00 0 0",
                 c, if8.s, if8.cout, if8.out_valid);
      end
    end
    rst_n = 1'b1;
    if1.in_valid = 1'b0;
    if8.in_valid = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [7:0] exp_s;
    logic [7:0] exp_c;
    logic [2:0] v;
    // Index i = {a,b,cin}.
    exp_s = 8'b1001_0110;
    exp_c = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      if1.in_valid = 1'b1;
      {if1.a, if1.b, if1.cin} = v;
      tick();
      n_cmp++;
      if (if1.s !== exp_s[i] || if1.cout !== exp_c[i] || if1.out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL truth_%b: got s=%b cout=%b vld=%b, want s=%b cout=%b vld=1",
                 v, if1.s, if1.cout, if1.out_valid, exp_s[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_hold();
    if1.in_valid = 1'b1; if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b0;
    tick();
    n_cmp++;
    if (if1.s !== 1'b0 || if1.cout !== 1'b0 || if1.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_capture: got s=%b cout=%b vld=%b, want 0 0 1",
               if1.s, if1.cout, if1.out_valid);
    end
    for (int c = 0; c < 3; c++) begin
      if1.in_valid = 1'b0;
      if1.a = 1'b0; if1.b = 1'b1; if1.cin = c[0];
      tick();
      n_cmp++;
      if (if1.s !== 1'b0 || if1.cout !== 1'b0 || if1.out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_cyc%0d: got s=%b cout=%b vld=%b, want 0 0 0",
                 c, if1.s, if1.cout, if1.out_valid);
      end
    end
  endtask

  task automatic test_wrap();
    if8.in_valid = 1'b1; if8.a = 8'h00; if8.b = 8'h01; if8.cin = 1'b0;
    tick();
    n_cmp++;
    if (if8.s !== 8'hFF || if8.cout !== 1'b1 || if8.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_00_01: got s=%h cout=%b vld=%b, want ff 1 1",
               if8.s, if8.cout, if8.out_valid);
    end
    if8.a = 8'h80; if8.b = 8'h7F; if8.cin = 1'b1;
    tick();
    n_cmp++;
    if (if8.s !== 8'h00 || if8.cout !== 1'b0 || if8.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_80_7f_1: got s=%h cout=%b vld=%b, want 00 0 1",
               if8.s, if8.cout, if8.out_valid);
    end
    if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1'b1;
    tick();
    n_cmp++;
    if (if8.s !== 8'hFF || if8.cout !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_ff_ff_1: got s=%h cout=%b, want ff 1", if8.s, if8.cout);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    logic [7:0] ra, rb;
    logic       rc;
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      if8.in_valid = 1'b1; if8.a = ra; if8.b = rb; if8.cin = rc;
      if (k == 500) begin
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (if8.s !== 8'h00 || if8.cout !== 1'b0 || if8.out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL midreset: got s=%h cout=%b vld=%b, want 00 0 0",
                   if8.s, if8.cout, if8.out_valid);
        end
        rst_n = 1'b1;
      end else begin
        exp = {1'b0, ra} - {1'b0, rb} - {8'h00, rc};
        tick();
        n_cmp++;
        if (if8.s !== exp[7:0] || if8.cout !== exp[8] || if8.out_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL rand_%0d %h-%h-%b: got s=%h cout=%b vld=%b, want s=%h cout=%b vld=1",
                   k, ra, rb, rc, if8.s, if8.cout, if8.out_valid, exp[7:0], exp[8]);
        end
      end
    end
    if8.in_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b1;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    test_reset();
    test_truth_table();
    test_hold();
    test_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
